// File: rtl/block_stats_buffer.sv
// Block statistics buffer: gathers TOTAL_SAMPLES pixels, computes mean and variance,
// then replays the stored pixels on contiguous cycles starting with the stats_ready pulse.
module block_stats_buffer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TOTAL_SAMPLES = 64,
  parameter int unsigned LOG2_SAMPLES  = $clog2(TOTAL_SAMPLES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      in_ready,
  output logic                      stats_ready,
  output logic [2*DATA_WIDTH-1:0]   mean_of_block,
  output logic [2*DATA_WIDTH-1:0]   variance_of_block,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_out_valid,
  output logic [31:0]               block_count
);

  localparam int unsigned SUM_W = DATA_WIDTH + LOG2_SAMPLES;
  localparam int unsigned SQ_W  = 2*DATA_WIDTH + LOG2_SAMPLES;
  localparam int unsigned OUT_W = 2*DATA_WIDTH;
  localparam logic [LOG2_SAMPLES-1:0] LAST_IDX = LOG2_SAMPLES'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_CALC, ST_REPLAY} state_t;

  state_t                  state_q, state_d;
  logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SUM_W-1:0]        sum_q, sum_d, sum_shr;
  logic [SQ_W-1:0]         sumsq_q, sumsq_d, sumsq_shr;
  logic [OUT_W-1:0]        mean_q, mean_d, var_q, var_d;
  logic [OUT_W-1:0]        mean_calc, sq_mean, mean_sq, pix_sq;
  logic                    in_ready_q, in_ready_d;
  logic                    stats_q, stats_d;
  logic                    dvalid_q, dvalid_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [31:0]             bc_q, bc_d;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   pix_mem [TOTAL_SAMPLES];

  assign accept  = valid_in && in_ready_q && (state_q == ST_ACCUM);
  assign cnt_inc = cnt_q + LOG2_SAMPLES'(1);

  // Pixel storage carries no reset; only entries written in the current block are ever replayed.
  always_ff @(posedge clk) begin
    if (accept) pix_mem[cnt_q] <= data_in;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    sumsq_d    = sumsq_q;
    mean_d     = mean_q;
    var_d      = var_q;
    in_ready_d = in_ready_q;
    stats_d    = 1'b0;
    dvalid_d   = 1'b0;
    dout_d     = dout_q;
    bc_d       = bc_q;

    sum_shr   = sum_q >> LOG2_SAMPLES;
    sumsq_shr = sumsq_q >> LOG2_SAMPLES;
    mean_calc = OUT_W'(sum_shr);
    sq_mean   = OUT_W'(sumsq_shr);
    mean_sq   = mean_calc * mean_calc;
    pix_sq    = OUT_W'(data_in) * OUT_W'(data_in);

    unique case (state_q)
      ST_ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          sum_d   = sum_q + SUM_W'(data_in);
          sumsq_d = sumsq_q + SQ_W'(pix_sq);
          cnt_d   = cnt_inc;
          if (cnt_q == LAST_IDX) begin
            cnt_d      = '0;
            in_ready_d = 1'b0;
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // Pixel 0 is loaded here so it leaves the register together with the stats pulse.
        mean_d   = mean_calc;
        var_d    = (sq_mean >= mean_sq) ? (sq_mean - mean_sq) : '0;
        stats_d  = 1'b1;
        dvalid_d = 1'b1;
        dout_d   = pix_mem[0];
        state_d  = ST_REPLAY;
      end
      ST_REPLAY: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d      = '0;
          sum_d      = '0;
          sumsq_d    = '0;
          bc_d       = bc_q + 32'd1;
          in_ready_d = 1'b1;
          state_d    = ST_ACCUM;
        end else begin
          dvalid_d = 1'b1;
          dout_d   = pix_mem[cnt_inc];
          cnt_d    = cnt_inc;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      sum_q      <= '0;
      sumsq_q    <= '0;
      mean_q     <= '0;
      var_q      <= '0;
      in_ready_q <= 1'b0;
      stats_q    <= 1'b0;
      dvalid_q   <= 1'b0;
      dout_q     <= '0;
      bc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      sumsq_q    <= sumsq_d;
      mean_q     <= mean_d;
      var_q      <= var_d;
      in_ready_q <= in_ready_d;
      stats_q    <= stats_d;
      dvalid_q   <= dvalid_d;
      dout_q     <= dout_d;
      bc_q       <= bc_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign stats_ready       = stats_q;
  assign mean_of_block     = mean_q;
  assign variance_of_block = var_q;
  assign data_out          = dout_q;
  assign data_out_valid    = dvalid_q;
  assign block_count       = bc_q;

endmodule

// File: tb/tb_block_stats_buffer.sv
// Directed/random bench for block_stats_buffer; expected stats come from plain arithmetic on the sent pixels.
module tb_block_stats_buffer;

  localparam int DW = 8;
  localparam int N  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic [DW-1:0]     data_in;
  logic              in_ready;
  logic              stats_ready;
  logic [2*DW-1:0]   mean_of_block;
  logic [2*DW-1:0]   variance_of_block;
  logic [DW-1:0]     data_out;
  logic              data_out_valid;
  logic [31:0]       block_count;

  int errors = 0;
  int checks = 0;
  longint exp_bc = 0;

  block_stats_buffer #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(N)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .valid_in          (valid_in),
    .data_in           (data_in),
    .in_ready          (in_ready),
    .stats_ready       (stats_ready),
    .mean_of_block     (mean_of_block),
    .variance_of_block (variance_of_block),
    .data_out          (data_out),
    .data_out_valid    (data_out_valid),
    .block_count       (block_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 all 100, 1 ramp, 2 alternating 0/255, 3 random
  task automatic run_block(input int mode, input bit gaps, input bit hold, input int abort_at);
    logic [DW-1:0] pix [N];
    longint sum, sq, mean, var_e;
    int idx, k;
    bit xfer;
    sum = 0; sq = 0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       pix[i] = 8'd100;
        1:       pix[i] = i[DW-1:0];
        2:       pix[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
        default: pix[i] = DW'($urandom_range(0, 255));
      endcase
      sum += longint'(pix[i]);
      sq  += longint'(pix[i]) * longint'(pix[i]);
    end
    mean  = sum / N;
    var_e = sq / N - mean * mean;
    if (var_e < 0) var_e = 0;

    idx = 0; k = 0;
    while (idx < N && k < 4*N) begin
      if (gaps && (k % 3 == 2)) begin
        valid_in = 1'b0;
        data_in  = DW'($urandom);
      end else begin
        valid_in = 1'b1;
        data_in  = pix[idx];
      end
      chk("in_ready_accum", in_ready, 1);
      xfer = valid_in && in_ready;
      @(posedge clk); #1;
      k++;
      if (xfer) idx++;
    end
    if (idx < N) begin
      chk("transfer_timeout", idx, N);
      valid_in = 1'b0;
      return;
    end

    // Cycle T+1: calculation cycle
    valid_in = hold;
    data_in  = 8'hFF;
    chk("calc_in_ready", in_ready, 0);
    chk("calc_stats_ready", stats_ready, 0);
    chk("calc_dout_valid", data_out_valid, 0);

    for (int r = 0; r < N; r++) begin
      @(posedge clk); #1;
      chk("replay_stats_ready", stats_ready, (r == 0) ? 1 : 0);
      chk("replay_dout_valid", data_out_valid, 1);
      chk("replay_data", data_out, pix[r]);
      chk("replay_in_ready", in_ready, 0);
      if (r == 0 || r == N-1) begin
        chk("mean", mean_of_block, mean);
        chk("variance", variance_of_block, var_e);
      end
      if (r == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_dout_valid", data_out_valid, 0);
        chk("abort_stats_ready", stats_ready, 0);
        chk("abort_block_count", block_count, 0);
        chk("abort_in_ready", in_ready, 0);
        valid_in = 1'b0;
        exp_bc = 0;
        return;
      end
    end

    @(posedge clk); #1;
    exp_bc++;
    chk("post_in_ready", in_ready, 1);
    chk("post_dout_valid", data_out_valid, 0);
    chk("post_stats_ready", stats_ready, 0);
    chk("block_count", block_count, exp_bc);
    chk("mean_hold", mean_of_block, mean);
    valid_in = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stats_ready", stats_ready, 0);
    chk("rst_mean", mean_of_block, 0);
    chk("rst_variance", variance_of_block, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_dout_valid", data_out_valid, 0);
    chk("rst_block_count", block_count, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_in_ready", in_ready, 1);

    run_block(0, 1'b0, 1'b0, -1);   // all 100s
    run_block(1, 1'b0, 1'b0, -1);   // ramp
    run_block(2, 1'b0, 1'b0, -1);   // alternating 0/255
    run_block(1, 1'b1, 1'b0, -1);   // ramp with bubbles
    run_block(0, 1'b0, 1'b1, -1);   // 0xFF held during CALC/REPLAY
    run_block(1, 1'b0, 1'b1, -1);
    run_block(3, 1'b1, 1'b0, -1);   // random
    run_block(3, 1'b0, 1'b1, -1);

    run_block(1, 1'b0, 1'b0, 10);   // reset during replay pixel 10
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerst_in_ready", in_ready, 1);
    chk("rerst_block_count", block_count, 0);
    run_block(1, 1'b0, 1'b0, -1);
    run_block(3, 1'b1, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_stats_buffer.md
Name: block_stats_buffer

Overview:
- Upstream neighbour of the Wiener computation stage.
- Collects one block of TOTAL_SAMPLES pixels and accumulates the sum and the sum of squares.
- Computes the block mean and variance, then pulses stats_ready and replays the buffered pixels on contiguous cycles, aligned to the timing the Wiener stage expects.
- Input is back-pressured with in_ready while a block is being computed or replayed.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- TOTAL_SAMPLES, 64, pixels per block. Must be a power of two, at least 2.
- LOG2_SAMPLES, $clog2(TOTAL_SAMPLES), shift amount used for the divide. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- valid_in  in  1  data_in carries a pixel this cycle.
- data_in  in  DATA_WIDTH  input pixel, raster order within the block.
- in_ready  out  1  block accepts a pixel this cycle. A transfer occurs when valid_in and in_ready are both high.
- stats_ready  out  1  one-cycle pulse; mean_of_block and variance_of_block are valid this cycle.
- mean_of_block  out  2*DATA_WIDTH  floor(sum/N), zero-extended.
- variance_of_block  out  2*DATA_WIDTH  floor(sumsq/N) - mean^2, clamped at 0.
- data_out  out  DATA_WIDTH  replayed pixel.
- data_out_valid  out  1  data_out is a replayed pixel.
- block_count  out  32  number of blocks fully replayed since reset; wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0): state ACCUM, sample counter 0, accumulators 0, in_ready=0, stats_ready=0, mean/variance=0, data_out=0, data_out_valid=0, block_count=0.
- After reset, in_ready goes high on the first clock edge.
- Storage:
  - Pixel buffer: TOTAL_SAMPLES x DATA_WIDTH registers or RAM.
  - sum accumulator: DATA_WIDTH+LOG2_SAMPLES bits.
  - sumsq accumulator: 2*DATA_WIDTH+LOG2_SAMPLES bits. No overflow is possible at these widths.
- State ACCUM:
  - in_ready=1.
  - On each transfer: buf[cnt]<=data_in, sum+=data_in, sumsq+=data_in*data_in, cnt++.
  - Cycles with valid_in=0 change nothing.
  - On the transfer with cnt==N-1: cnt<=0, go to CALC, and in_ready drops on the next cycle.
- State CALC (exactly 1 cycle):
  - in_ready=0.
  - Register mean = sum>>LOG2_SAMPLES.
  - Register variance = (sumsq>>LOG2_SAMPLES) - mean*mean, clamped to 0 if negative. It never goes negative for valid data; the clamp is a safety net.
  - Go to REPLAY.
- State REPLAY (exactly N cycles):
  - in_ready=0.
  - On the first cycle: stats_ready=1, data_out=buf[0], data_out_valid=1.
  - On the following N-1 cycles: data_out=buf[1..N-1], data_out_valid=1, stats_ready=0.
  - mean_of_block and variance_of_block hold their values until the next CALC.
  - After the last pixel: clear the accumulators, block_count++, go to ACCUM. in_ready=1 on the cycle after the last replayed pixel.
- Latency: if the last pixel transfers on cycle T, then:
  - CALC runs on T+1.
  - stats_ready and pixel 0 appear on T+2.
  - Pixel N-1 appears on T+N+1.
  - in_ready is high again on T+N+2.
- All outputs are registered.
- The replay must never stall: the downstream stage counts cycles, not valids.
- valid_in while in_ready=0: the input is ignored; no pixel is accepted or lost from the buffer.
- Reset mid-block or mid-replay: immediate abort, all state cleared, no stats_ready pulse, block_count unchanged from its reset value of 0.
- Back-to-back blocks: pixel 0 of the next block can transfer on T+N+2 at the earliest.

Test Plan:
- 64 pixels of 100, valid every cycle -> stats_ready pulse 2 cycles after the last transfer; mean=100, variance=0; data_out=100 for 64 cycles; block_count=1.
- Ramp 0..63 -> mean=31 (2016/64), variance=1333-961=372; data_out replays 0..63 in order on consecutive cycles starting with the stats_ready cycle.
- Alternating 0,255 -> mean=127, variance=32512-16129=16383; no overflow in sumsq (2080800).
- Ramp with valid_in=0 inserted every third cycle -> same results as the ramp case; the stats_ready cycle is set by the 64th transfer only.
- valid_in held high during CALC/REPLAY with value 0xFF -> in_ready=0 throughout, buffer and results unaffected; two consecutive blocks (100s, then ramp) give block_count=2 and correct stats for each.
- Assert rst_n=0 on replay pixel 10 -> data_out_valid=0, stats_ready=0, block_count=0 immediately; a fresh block afterwards yields correct stats.
